// File: rtl/vector_output_streamer.sv
// ============================================================================
// Module  : vector_output_streamer
// Purpose : Buffers CPU output vectors in a FIFO and streams them out one
//           element per handshake, lowest element index first.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vector_output_streamer #(
  parameter int DATA_WIDTH  = 19,
  parameter int VECTOR_SIZE = 6,
  parameter int DEPTH       = 4
) (
  input  logic                                clock_i,
  input  logic                                reset_ni,
  input  logic [VECTOR_SIZE*DATA_WIDTH-1:0]   vectorIn_i,
  input  logic                                vectorFlag_i,
  output logic [DATA_WIDTH-1:0]               wordData_o,
  output logic                                wordValid_o,
  input  logic                                wordReady_i,
  output logic                                wordLast_o,
  output logic [$clog2(VECTOR_SIZE)-1:0]      elementIndex_o,
  output logic [$clog2(DEPTH):0]              fifoCount_o,
  output logic                                overflow_o,
  input  logic                                clearOverflow_i
);

  localparam int VW = VECTOR_SIZE * DATA_WIDTH;
  localparam int IW = $clog2(VECTOR_SIZE);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [IW-1:0] LAST_IDX = IW'(VECTOR_SIZE - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [VW-1:0] hold_q, hold_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [VW-1:0] mem_q [DEPTH];

  logic w_send;
  logic w_accept;
  logic w_last;
  logic w_pop;
  logic w_push;

  assign w_send   = (state_q == S_SEND);
  assign w_accept = w_send && wordReady_i;
  assign w_last   = w_send && (idx_q == LAST_IDX);
  // A pop frees a slot on the same edge, so a full FIFO can still take a push.
  assign w_pop    = (count_q != '0) && (!w_send || (w_accept && w_last));
  assign w_push   = vectorFlag_i && ((count_q != DEPTH_C) || w_pop);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    hold_d   = hold_q;
    wr_ptr_d = wr_ptr_q + PW'(w_push);
    rd_ptr_d = rd_ptr_q + PW'(w_pop);
    count_d  = count_q + CW'(w_push) - CW'(w_pop);
    ovf_d    = ovf_q;

    if (w_pop) begin
      hold_d  = mem_q[rd_ptr_q];
      idx_d   = '0;
      state_d = S_SEND;
    end else if (w_accept) begin
      if (w_last) begin
        idx_d   = '0;
        state_d = S_IDLE;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end

    if (vectorFlag_i && !w_push) begin
      ovf_d = 1'b1;
    end else if (clearOverflow_i) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      hold_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      hold_q   <= hold_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array carries no reset; entries are only read after being written.
  always_ff @(posedge clock_i) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= vectorIn_i;
    end
  end

  assign wordValid_o    = w_send;
  assign wordData_o     = w_send ? hold_q[idx_q*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign wordLast_o     = w_last;
  assign elementIndex_o = idx_q;
  assign fifoCount_o    = count_q;
  assign overflow_o     = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_vector_output_streamer.sv
// ============================================================================
// Module  : tb_vector_output_streamer
// Purpose : Self-checking bench for vector_output_streamer with a queue model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vector_output_streamer;

  localparam int DW    = 19;
  localparam int VS    = 6;
  localparam int DEPTH = 4;
  localparam int VW    = VS * DW;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic [VW-1:0] vin     = '0;
  logic          flag    = 1'b0;
  logic          ready   = 1'b0;
  logic          clr     = 1'b0;
  logic [DW-1:0] data;
  logic          valid;
  logic          last;
  logic [$clog2(VS)-1:0]  idx_o;
  logic [$clog2(DEPTH):0] cnt_o;
  logic          ovf;

  vector_output_streamer #(
    .DATA_WIDTH (DW),
    .VECTOR_SIZE(VS),
    .DEPTH      (DEPTH)
  ) dut (
    .clock_i        (clk),
    .reset_ni       (rst_n),
    .vectorIn_i     (vin),
    .vectorFlag_i   (flag),
    .wordData_o     (data),
    .wordValid_o    (valid),
    .wordReady_i    (ready),
    .wordLast_o     (last),
    .elementIndex_o (idx_o),
    .fifoCount_o    (cnt_o),
    .overflow_o     (ovf),
    .clearOverflow_i(clr)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of pending vectors plus the vector on the wire.
  bit            m_busy;
  int            m_idx;
  logic [VW-1:0] m_cur;
  logic [VW-1:0] m_fifo[$];
  bit            m_ovf;

  int n_checks = 0;
  int n_errors = 0;
  int dut_hs   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] elem(input logic [VW-1:0] v, input int k);
    return v[k*DW +: DW];
  endfunction

  function automatic logic [VW-1:0] mkvec(input int base);
    logic [VW-1:0] v;
    v = '0;
    for (int k = 0; k < VS; k++) v[k*DW +: DW] = DW'(base + k);
    return v;
  endfunction

  function automatic logic [VW-1:0] rndvec();
    logic [VW-1:0] v;
    v = '0;
    for (int k = 0; k < VS; k++) v[k*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_idx  = 0;
    m_cur  = '0;
    m_fifo.delete();
    m_ovf  = 1'b0;
  endtask

  task automatic model_step();
    bit ending, take, put;
    ending = m_busy && ready && (m_idx == VS - 1);
    take   = (m_fifo.size() > 0) && (!m_busy || ending);
    put    = flag && ((m_fifo.size() < DEPTH) || take);
    if (take) begin
      m_cur  = m_fifo.pop_front();
      m_idx  = 0;
      m_busy = 1'b1;
    end else if (m_busy && ready) begin
      if (ending) begin
        m_busy = 1'b0;
        m_idx  = 0;
      end else begin
        m_idx++;
      end
    end
    if (put) m_fifo.push_back(vin);
    if (flag && !put) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  task automatic compare_all();
    chk("valid", valid, m_busy);
    chk("data",  data,  m_busy ? elem(m_cur, m_idx) : '0);
    chk("last",  last,  m_busy && (m_idx == VS - 1));
    chk("index", idx_o, m_idx);
    chk("count", cnt_o, m_fifo.size());
    chk("ovf",   ovf,   m_ovf);
  endtask

  task automatic cycle();
    if (valid && ready) dut_hs++;
    @(posedge clk);
    if (rst_n) model_step();
    else model_reset();
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic push_one(input logic [VW-1:0] v);
    vin  = v;
    flag = 1'b1;
    cycle();
    flag = 1'b0;
  endtask

  int  hs0;
  bit  fp_done;
  int  guard;
  bit  pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    model_reset();
    #12;
    chk("rst_valid", valid, 0);
    chk("rst_data",  data,  0);
    chk("rst_count", cnt_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(2);

    // Single vector 1..6: latency and wordLast placement.
    ready = 1'b1;
    push_one(mkvec(1));
    chk("lat_count1", cnt_o, 1);
    chk("lat_valid0", valid, 0);
    cycle();
    chk("lat_valid1", valid, 1);
    chk("lat_elem0",  data,  1);
    run(4);
    chk("lat_nolast", last, 0);
    cycle();
    chk("lat_last",   last, 1);
    chk("lat_elem5",  data, 6);
    run(3);
    chk("single_idle", valid, 0);

    // Backpressure with ready pattern 1,0,0,1.
    hs0 = dut_hs;
    push_one(mkvec(1));
    for (int i = 0; i < 30; i++) begin
      ready = pat[i % 4];
      cycle();
    end
    chk("bp_handshakes", dut_hs - hs0, 6);

    // Burst of six flags with the sink stalled.
    ready = 1'b0;
    for (int i = 0; i < 6; i++) push_one(mkvec(32 * (i + 1)));
    chk("burst_count", cnt_o, DEPTH);
    chk("burst_ovf",   ovf,   1);
    hs0 = dut_hs;
    ready = 1'b1;
    run(35);
    chk("burst_words", dut_hs - hs0, 30);
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    chk("ovf_cleared", ovf, 0);

    // Back-to-back vectors, ready held high.
    hs0 = dut_hs;
    push_one(mkvec(200));
    push_one(mkvec(300));
    run(16);
    chk("b2b_words", dut_hs - hs0, 12);

    // Full FIFO with a push on the same edge as the final pop of a vector.
    ready = 1'b0;
    for (int i = 0; i < 5; i++) push_one(mkvec(400 + 8 * i));
    ready   = 1'b1;
    fp_done = 1'b0;
    for (int i = 0; i < 12 && !fp_done; i++) begin
      if (m_busy && m_idx == VS - 1 && m_fifo.size() == DEPTH) begin
        vin  = mkvec(500);
        flag = 1'b1;
        cycle();
        flag = 1'b0;
        fp_done = 1'b1;
        chk("fp_count", cnt_o, DEPTH);
        chk("fp_ovf",   ovf,   0);
      end else begin
        cycle();
      end
    end
    chk("fp_reached", fp_done, 1);
    run(40);

    // Asynchronous reset after the third word.
    hs0 = dut_hs;
    push_one(mkvec(600));
    guard = 0;
    while ((dut_hs - hs0) < 3 && guard < 20) begin
      cycle();
      guard++;
    end
    chk("mid_reached", dut_hs - hs0, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", valid, 0);
    chk("arst_data",  data,  0);
    chk("arst_last",  last,  0);
    chk("arst_index", idx_o, 0);
    chk("arst_count", cnt_o, 0);
    model_reset();
    run(2);
    rst_n = 1'b1;
    hs0 = dut_hs;
    push_one(mkvec(7));
    run(10);
    chk("post_rst_words", dut_hs - hs0, 6);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      vin   = rndvec();
      flag  = ($urandom_range(0, 99) < 30);
      ready = ($urandom_range(0, 99) < 60);
      clr   = ($urandom_range(0, 99) < 5);
      cycle();
    end
    flag  = 1'b0;
    clr   = 1'b0;
    ready = 1'b1;
    run(40);
    chk("final_idle", valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vector_output_streamer.md
# vector_output_streamer

Hardware consumer for the CPU's vector output port. Captures each `out` vector on the cycles `outFlag` is high, buffers up to DEPTH vectors, and streams them as DATA_WIDTH-bit elements over a valid/ready word interface to a host link or output peripheral. It replaces the simulation-only capture of `out`/`outFlag` with synthesizable logic that preserves the same element order and never silently loses data.

## Interface
- DATA_WIDTH, 19: element width, same as the CPU.
- VECTOR_SIZE, 6: elements per vector.
- DEPTH, 4: vector FIFO entries; power of two, at least 2.
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- vectorIn  in  VECTOR_SIZE*DATA_WIDTH  CPU `out`; element k is bits [k*DATA_WIDTH +: DATA_WIDTH].
- vectorFlag  in  1  CPU `outFlag`; the vector is captured on every edge where this is high.
- wordData  out  DATA_WIDTH  current element.
- wordValid  out  1  wordData is valid.
- wordReady  in  1  sink accepts the word on an edge where both wordValid and wordReady are high.
- wordLast  out  1  high with element VECTOR_SIZE-1.
- elementIndex  out  $clog2(VECTOR_SIZE)  index of the current element.
- fifoCount  out  $clog2(DEPTH)+1  number of buffered vectors, excluding the one being sent.
- overflow  out  1  sticky; set when a captured vector was dropped.
- clearOverflow  in  1  synchronous clear of overflow.

## Operation
- Storage: a DEPTH-entry FIFO of full vectors with wrap-around read/write pointers, plus a shift/hold register for the vector currently being sent.
- Push: happens on an edge with vectorFlag=1, when count<DEPTH or a pop occurs on the same edge.
  - Otherwise the vector is dropped and overflow is set.
  - If the same edge also has clearOverflow=1, set takes priority.
- Pop: the FIFO head is loaded into the hold register whenever the streamer takes a new vector (see FSM).
- FSM, state IDLE:
  - wordValid=0.
  - If fifoCount>0: load the head, pop, elementIndex=0, go to SEND.
- FSM, state SEND:
  - wordValid=1; wordData = element[elementIndex] of the hold register; wordLast = (elementIndex==VECTOR_SIZE-1).
  - Accepted word with elementIndex<VECTOR_SIZE-1: elementIndex increments.
  - Accepted word with wordLast=1 and fifoCount>0: load the next head, pop, elementIndex=0, stay in SEND. There is no bubble.
  - Accepted word with wordLast=1 and fifoCount=0: go to IDLE.
- While wordValid=1 and wordReady=0, wordData, wordLast and elementIndex hold stable.
- Elements are sent lowest index first, matching the CPU packed layout.

## Timing
- Reset values: wordValid=0, wordData=0, wordLast=0, elementIndex=0, fifoCount=0, overflow=0, FSM=IDLE, both pointers=0.
- Reset mid-transfer discards the in-flight vector and all buffered vectors. The first vectorFlag after reset deasserts is captured normally.
- Latency, empty block, vectorFlag high at edge t:
  - fifoCount=1 after edge t.
  - wordValid=1 with element 0 after edge t+1.
  - With wordReady held high, wordLast appears after edge t+VECTOR_SIZE.
- Throughput: one element per cycle with wordReady high; back-to-back vectors have no idle cycle.
- Simultaneous push and pop at fifoCount=DEPTH: the push is accepted and fifoCount is unchanged.
- Simultaneous push and pop at fifoCount=0: cannot occur, since a pop needs a stored entry. The pushed vector becomes visible in the following cycle.
- fifoCount never exceeds DEPTH. Pointers wrap modulo DEPTH.

## Test plan
- Single vector 1,2,3,4,5,6 with wordReady=1 → wordValid rises 2 edges after the flag; words 1..6 on consecutive cycles; wordLast only with 6; then IDLE.
- Backpressure: wordReady toggles 1,0,0,1,… during the vector 1..6 → each word holds stable while ready is low; order is preserved; exactly 6 handshakes.
- Burst: 6 consecutive flags (vectors A..F) with wordReady=0 → A goes to the hold register, B..E fill the FIFO (fifoCount=4), F is dropped with overflow=1; releasing ready yields A..E, 30 words. A clearOverflow pulse then clears overflow.
- Back-to-back: two vectors, ready always high → 12 consecutive valid words, wordLast on words 6 and 12, no gap.
- Full plus simultaneous pop: fifoCount=4, flag on the cycle the last word of the current vector is accepted → push accepted, fifoCount stays 4, overflow stays 0.
- Reset asserted asynchronously mid-vector (after word 3) → outputs return to reset values immediately with no further words; a new vector 7..12 after release streams correctly.
